// File: rtl/kronos_mem_arb_pkg.sv
// Shared types for the Kronos instruction/data memory arbiter.
package kronos_mem_arb_pkg;

    typedef enum logic {
        OWNER_INSTR = 1'b0,
        OWNER_DATA  = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
        logic   we;
    } inflight_t;

    localparam int unsigned MAX_MEM_LATENCY = 4;

endpackage

// File: rtl/kronos_mem_arb_rsp_pipe.sv
// Response tracking shift register: one inflight_t entry per cycle, head emerges
// Depth cycles after push. Asynchronous clear drops every outstanding entry.
module kronos_mem_arb_rsp_pipe
    import kronos_mem_arb_pkg::*;
#(
    parameter int unsigned Depth = 1
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  inflight_t push_i,
    output inflight_t head_o
);

    inflight_t stage_q [Depth];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= push_i;
            for (int unsigned i = 1; i < Depth; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign head_o = stage_q[Depth-1];

endmodule

// File: rtl/kronos_mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency SRAM between the Kronos instruction
// and data ports. Define KRONOS_MEM_ARB_PERF_EN to add saturating conflict/wait counters.
module kronos_mem_arbiter
    import kronos_mem_arb_pkg::*;
#(
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned AddrWidth  = 32,
    parameter int unsigned AddrShift  = 2,
    parameter int unsigned MemLatency = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 instr_req_i,
    output logic                 instr_gnt_o,
    input  logic [AddrWidth-1:0] instr_addr_i,
    input  logic [DataWidth-1:0] instr_wdata_i,
    input  logic [DataWidth-1:0] instr_strb_i,
    input  logic                 instr_we_i,
    output logic [DataWidth-1:0] instr_rdata_o,
    output logic                 instr_rvalid_o,
    input  logic                 data_req_i,
    output logic                 data_gnt_o,
    input  logic [AddrWidth-1:0] data_addr_i,
    input  logic [DataWidth-1:0] data_wdata_i,
    input  logic [DataWidth-1:0] data_strb_i,
    input  logic                 data_we_i,
    output logic [DataWidth-1:0] data_rdata_o,
    output logic                 data_rvalid_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [DataWidth-1:0] mem_wdata_o,
    output logic [DataWidth-1:0] mem_strb_o,
    input  logic [DataWidth-1:0] mem_rdata_i
`ifdef KRONOS_MEM_ARB_PERF_EN
    ,
    output logic [31:0]          conflict_cnt_o,
    output logic [31:0]          instr_wait_cnt_o,
    output logic [31:0]          data_wait_cnt_o
`endif
);

    if (MemLatency == 0 || MemLatency > MAX_MEM_LATENCY) begin : g_bad_latency
        $fatal(1, "kronos_mem_arbiter: MemLatency must be in 1..%0d", MAX_MEM_LATENCY);
    end

    owner_e               ptr_q, ptr_d;
    logic                 conflict;
    inflight_t            push, head;
    logic [DataWidth-1:0] instr_hold_q, data_hold_q;

    assign conflict    = instr_req_i & data_req_i;
    assign instr_gnt_o = instr_req_i & (~data_req_i | (ptr_q == OWNER_INSTR));
    assign data_gnt_o  = data_req_i & (~instr_req_i | (ptr_q == OWNER_DATA));
    assign mem_req_o   = instr_req_i | data_req_i;

    // Priority passes to the loser only when both ports collide.
    always_comb begin
        ptr_d = ptr_q;
        if (conflict) begin
            ptr_d = (ptr_q == OWNER_DATA) ? OWNER_INSTR : OWNER_DATA;
        end
    end

    always_comb begin
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_strb_o  = '0;
        push        = '0;
        if (instr_gnt_o) begin
            mem_we_o    = instr_we_i;
            mem_addr_o  = instr_addr_i >> AddrShift;
            mem_wdata_o = instr_wdata_i;
            mem_strb_o  = instr_strb_i;
            push        = '{valid: 1'b1, owner: OWNER_INSTR, we: instr_we_i};
        end else if (data_gnt_o) begin
            mem_we_o    = data_we_i;
            mem_addr_o  = data_addr_i >> AddrShift;
            mem_wdata_o = data_wdata_i;
            mem_strb_o  = data_strb_i;
            push        = '{valid: 1'b1, owner: OWNER_DATA, we: data_we_i};
        end
    end

    kronos_mem_arb_rsp_pipe #(
        .Depth (MemLatency)
    ) u_rsp_pipe (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push_i (push),
        .head_o (head)
    );

    // Write acks pulse rvalid but leave the held read data untouched.
    always_comb begin
        instr_rvalid_o = head.valid & (head.owner == OWNER_INSTR);
        data_rvalid_o  = head.valid & (head.owner == OWNER_DATA);
        instr_rdata_o  = (instr_rvalid_o & ~head.we) ? mem_rdata_i : instr_hold_q;
        data_rdata_o   = (data_rvalid_o & ~head.we) ? mem_rdata_i : data_hold_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q        <= OWNER_DATA;
            instr_hold_q <= '0;
            data_hold_q  <= '0;
        end else begin
            ptr_q        <= ptr_d;
            instr_hold_q <= instr_rdata_o;
            data_hold_q  <= data_rdata_o;
        end
    end

`ifdef KRONOS_MEM_ARB_PERF_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            conflict_cnt_o   <= '0;
            instr_wait_cnt_o <= '0;
            data_wait_cnt_o  <= '0;
        end else begin
            if (conflict && (conflict_cnt_o != '1)) begin
                conflict_cnt_o <= conflict_cnt_o + 32'd1;
            end
            if (instr_req_i && !instr_gnt_o && (instr_wait_cnt_o != '1)) begin
                instr_wait_cnt_o <= instr_wait_cnt_o + 32'd1;
            end
            if (data_req_i && !data_gnt_o && (data_wait_cnt_o != '1)) begin
                data_wait_cnt_o <= data_wait_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_kronos_mem_arbiter.sv
// Bench: two arbiters (latency 1 and 3) on shared stimulus, each with its own SRAM model,
// checked against a transaction-level reference model.
module tb_kronos_mem_arbiter;

    localparam int NumDut = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req   [2];
    logic        we    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [31:0] strb  [2];

    logic        gnt    [NumDut][2];
    logic        rvalid [NumDut][2];
    logic [31:0] rdata  [NumDut][2];
    logic        mem_req   [NumDut];
    logic        mem_we    [NumDut];
    logic [31:0] mem_addr  [NumDut];
    logic [31:0] mem_wdata [NumDut];
    logic [31:0] mem_strb  [NumDut];
    logic [31:0] mem_rdata [NumDut];
`ifdef KRONOS_MEM_ARB_PERF_EN
    logic [31:0] conf_cnt [NumDut];
    logic [31:0] iw_cnt   [NumDut];
    logic [31:0] dw_cnt   [NumDut];
`endif

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return 32'hA5C3_0000 ^ (i * 32'h0101_0107);
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    for (genvar g = 0; g < NumDut; g++) begin : g_dut
        localparam int unsigned Lat = (g == 0) ? 1 : 3;
        bit   [31:0] delta [128];
        bit   [31:0] pipe  [4];
        logic [6:0]  widx;
        logic [31:0] cur_w;

        kronos_mem_arbiter #(
            .DataWidth  (32),
            .AddrWidth  (32),
            .AddrShift  (2),
            .MemLatency (Lat)
        ) u_dut (
            .clk_i          (clk),
            .rst_ni         (rst_n),
            .instr_req_i    (req[0]),
            .instr_gnt_o    (gnt[g][0]),
            .instr_addr_i   (addr[0]),
            .instr_wdata_i  (wdata[0]),
            .instr_strb_i   (strb[0]),
            .instr_we_i     (we[0]),
            .instr_rdata_o  (rdata[g][0]),
            .instr_rvalid_o (rvalid[g][0]),
            .data_req_i     (req[1]),
            .data_gnt_o     (gnt[g][1]),
            .data_addr_i    (addr[1]),
            .data_wdata_i   (wdata[1]),
            .data_strb_i    (strb[1]),
            .data_we_i      (we[1]),
            .data_rdata_o   (rdata[g][1]),
            .data_rvalid_o  (rvalid[g][1]),
            .mem_req_o      (mem_req[g]),
            .mem_we_o       (mem_we[g]),
            .mem_addr_o     (mem_addr[g]),
            .mem_wdata_o    (mem_wdata[g]),
            .mem_strb_o     (mem_strb[g]),
            .mem_rdata_i    (mem_rdata[g])
`ifdef KRONOS_MEM_ARB_PERF_EN
            ,
            .conflict_cnt_o   (conf_cnt[g]),
            .instr_wait_cnt_o (iw_cnt[g]),
            .data_wait_cnt_o  (dw_cnt[g])
`endif
        );

        // SRAM model: contents stored as XOR against the power-up image.
        assign widx  = mem_addr[g][6:0];
        assign cur_w = delta[widx] ^ init_word(int'(widx));

        always @(posedge clk) begin
            if (mem_req[g] && mem_we[g]) begin
                delta[widx] <= ((cur_w & ~mem_strb[g]) | (mem_wdata[g] & mem_strb[g]))
                               ^ init_word(int'(widx));
            end
            pipe[0] <= (mem_req[g] && !mem_we[g]) ? cur_w : 32'($urandom);
            for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
        end

        assign mem_rdata[g] = pipe[Lat-1];
    end

    // Reference model state
    typedef struct {
        int          dut;
        int          due;
        int          port;
        bit          we;
        logic [31:0] data;
    } rsp_t;

    rsp_t        rq [$];
    logic [31:0] ref_mem [128];
    logic [31:0] hold_m [NumDut][2];
    int          prio;
    int          conf_m;
    int          wait_m [2];
    int          cyc = 0;

    bit          p_req   [2];
    bit          p_we    [2];
    int          p_idx   [2];
    logic [31:0] p_wdata [2];
    logic [31:0] p_strb  [2];

    int checks = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %08h, want %08h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int p, input bit w, input int idx,
                           input logic [31:0] wd, input logic [31:0] sb);
        p_req[p]   = 1'b1;
        p_we[p]    = w;
        p_idx[p]   = idx;
        p_wdata[p] = wd;
        p_strb[p]  = sb;
    endtask

    task automatic rand_req(input int p);
        set_req(p, $urandom_range(0, 2) == 0, $urandom_range(0, 127), 32'($urandom),
                ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom));
    endtask

    // One clock cycle: drive pending requests, check at negedge, advance model.
    task automatic run_cycle();
        bit          g_i, g_d, any;
        int          win;
        bit          ev [2];
        logic [31:0] old;
        for (int p = 0; p < 2; p++) begin
            req[p]   = p_req[p];
            we[p]    = p_we[p];
            addr[p]  = 32'h8000_0000 + (32'(p_idx[p]) << 2);
            wdata[p] = p_wdata[p];
            strb[p]  = p_strb[p];
        end
        g_i = p_req[0] && (!p_req[1] || prio == 0);
        g_d = p_req[1] && (!p_req[0] || prio == 1);
        any = g_i || g_d;
        win = g_d ? 1 : 0;
        @(negedge clk);
        for (int d = 0; d < NumDut; d++) begin
            check_val($sformatf("c%0d d%0d instr_gnt", cyc, d), 32'(gnt[d][0]), 32'(g_i));
            check_val($sformatf("c%0d d%0d data_gnt", cyc, d), 32'(gnt[d][1]), 32'(g_d));
            check_val($sformatf("c%0d d%0d mem_req", cyc, d), 32'(mem_req[d]), 32'(any));
            check_val($sformatf("c%0d d%0d mem_we", cyc, d), 32'(mem_we[d]),
                      any ? 32'(p_we[win]) : 32'd0);
            check_val($sformatf("c%0d d%0d mem_addr", cyc, d), mem_addr[d],
                      any ? 32'h2000_0000 + 32'(p_idx[win]) : 32'd0);
            check_val($sformatf("c%0d d%0d mem_wdata", cyc, d), mem_wdata[d],
                      any ? p_wdata[win] : 32'd0);
            check_val($sformatf("c%0d d%0d mem_strb", cyc, d), mem_strb[d],
                      any ? p_strb[win] : 32'd0);
            ev[0] = 1'b0;
            ev[1] = 1'b0;
            for (int i = rq.size() - 1; i >= 0; i--) begin
                if (rq[i].dut == d && rq[i].due == cyc) begin
                    ev[rq[i].port] = 1'b1;
                    if (!rq[i].we) hold_m[d][rq[i].port] = rq[i].data;
                    rq.delete(i);
                end
            end
            for (int p = 0; p < 2; p++) begin
                check_val($sformatf("c%0d d%0d p%0d rvalid", cyc, d, p), 32'(rvalid[d][p]),
                          32'(ev[p]));
                check_val($sformatf("c%0d d%0d p%0d rdata", cyc, d, p), rdata[d][p],
                          hold_m[d][p]);
            end
`ifdef KRONOS_MEM_ARB_PERF_EN
            check_val($sformatf("c%0d d%0d conflict_cnt", cyc, d), conf_cnt[d], conf_m);
            check_val($sformatf("c%0d d%0d instr_wait", cyc, d), iw_cnt[d], wait_m[0]);
            check_val($sformatf("c%0d d%0d data_wait", cyc, d), dw_cnt[d], wait_m[1]);
`endif
        end
        if (p_req[0] && p_req[1]) begin
            conf_m++;
            prio = 1 - prio;
        end
        if (p_req[0] && !g_i) wait_m[0]++;
        if (p_req[1] && !g_d) wait_m[1]++;
        if (any) begin
            old = ref_mem[p_idx[win]];
            for (int d = 0; d < NumDut; d++) begin
                rq.push_back('{d, cyc + lat_of(d), win, p_we[win], old});
            end
            if (p_we[win]) begin
                ref_mem[p_idx[win]] = (old & ~p_strb[win]) | (p_wdata[win] & p_strb[win]);
            end
            p_req[win] = 1'b0;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        p_req[0] = 1'b0;
        p_req[1] = 1'b0;
        req[0]   = 1'b0;
        req[1]   = 1'b0;
        rst_n    = 1'b0;
        rq.delete();
        prio      = 1;
        conf_m    = 0;
        wait_m[0] = 0;
        wait_m[1] = 0;
        for (int d = 0; d < NumDut; d++) begin
            hold_m[d][0] = '0;
            hold_m[d][1] = '0;
        end
        @(negedge clk);
        for (int d = 0; d < NumDut; d++) begin
            check_val($sformatf("rst c%0d d%0d mem_req", cyc, d), 32'(mem_req[d]), 32'd0);
            for (int p = 0; p < 2; p++) begin
                check_val($sformatf("rst c%0d d%0d p%0d gnt", cyc, d, p), 32'(gnt[d][p]), 32'd0);
                check_val($sformatf("rst c%0d d%0d p%0d rvalid", cyc, d, p),
                          32'(rvalid[d][p]), 32'd0);
                check_val($sformatf("rst c%0d d%0d p%0d rdata", cyc, d, p), rdata[d][p], 32'd0);
            end
        end
        @(posedge clk);
        cyc++;
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] w, exp_merge;
        for (int i = 0; i < 128; i++) ref_mem[i] = init_word(i);
        for (int p = 0; p < 2; p++) begin
            p_req[p] = 1'b0; p_we[p] = 1'b0; p_idx[p] = 0; p_wdata[p] = '0; p_strb[p] = '0;
            req[p] = 1'b0; we[p] = 1'b0; addr[p] = '0; wdata[p] = '0; strb[p] = '0;
        end
        rst_n = 1'b1;
        #1;
        do_reset();

        // Instr read of 0x8000_0010, then idle: data held, single rvalid pulse.
        set_req(0, 1'b0, 4, '0, '0);
        run_cycle();
        check_val("s1 instr_rvalid lat1", 32'(rvalid[0][0]), 32'd1);
        check_val("s1 instr_rdata lat1", rdata[0][0], init_word(4));
        check_val("s1 data_rvalid lat1", 32'(rvalid[0][1]), 32'd0);
        repeat (5) run_cycle();
        check_val("s6 instr_rdata held lat1", rdata[0][0], init_word(4));
        check_val("s6 instr_rdata held lat3", rdata[1][0], init_word(4));

        // Both ports request every cycle right after reset.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            for (int p = 0; p < 2; p++) begin
                if (!p_req[p]) set_req(p, 1'b0, $urandom_range(0, 127), '0, '0);
            end
            run_cycle();
        end
`ifdef KRONOS_MEM_ARB_PERF_EN
        check_val("s2 conflict_cnt", conf_cnt[0], 32'd4);
        check_val("s2 instr_wait", iw_cnt[0], 32'd2);
        check_val("s2 data_wait", dw_cnt[0], 32'd2);
`endif
        repeat (5) run_cycle();

        // Half-word masked write then read back.
        set_req(1, 1'b1, 64, 32'hDEAD_BEEF, 32'h0000_FFFF);
        run_cycle();
        set_req(1, 1'b0, 64, '0, '0);
        run_cycle();
        w = init_word(64);
        exp_merge = {w[31:16], 16'hBEEF};
        check_val("s3 data_rvalid", 32'(rvalid[0][1]), 32'd1);
        check_val("s3 merged rdata", rdata[0][1], exp_merge);
        repeat (4) run_cycle();

        // Alternating single-port reads every cycle.
        for (int k = 0; k < 12; k++) begin
            set_req(k % 2, 1'b0, $urandom_range(0, 127), '0, '0);
            run_cycle();
        end
        repeat (4) run_cycle();

        // Reset with reads in flight, then a conflict to confirm data priority.
        set_req(0, 1'b0, 10, '0, '0);
        run_cycle();
        set_req(1, 1'b0, 11, '0, '0);
        run_cycle();
        do_reset();
        repeat (5) run_cycle();
        set_req(0, 1'b0, 20, '0, '0);
        set_req(1, 1'b0, 21, '0, '0);
        run_cycle();
        repeat (5) run_cycle();

        // Random traffic.
        repeat (400) begin
            for (int p = 0; p < 2; p++) begin
                if (!p_req[p] && $urandom_range(0, 1) == 1) rand_req(p);
            end
            run_cycle();
        end
        repeat (8) run_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
